// File: rtl/input_trigger_mc_pkg.sv
// input_trigger_pkg: FSM state encoding and lowest-set-bit helper for input_trigger_mc
package input_trigger_pkg;
  typedef enum logic [1:0] {IDLE, CALC, REFRESH, DEBOUNCE} state_t;
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest_idx = 4'(i);
  endfunction
endpackage

// File: rtl/input_trigger_mc_sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser plus per-channel rise/fall edge events
module sync_edge_detect #(
  parameter int CHANNELS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  output logic [CHANNELS-1:0] ev
);
  logic [CHANNELS-1:0] s1, trig_s, prev;
  logic [2:0] first_flag;
  always_ff @(posedge clk)
    if (!reset) begin
      s1 <= '0;
      trig_s <= '0;
      prev <= '0;
      first_flag <= '0;
    end else begin
      s1 <= trigger;
      trig_s <= s1;
      prev <= trig_s;
      first_flag <= {first_flag[1:0], 1'b1};
    end
  // events stay masked until prev holds a post-reset sample, so static-high inputs never fire
  assign ev = first_flag[2] ? ((trig_s & ~prev & rise_en) | (~trig_s & prev & fall_en)) : '0;
endmodule

// File: rtl/input_trigger_mc.sv
// input_trigger_mc: multi-channel edge trigger producing inc/ref pulses with debounce lockout
module input_trigger_mc
  import input_trigger_pkg::*;
#(
  parameter int CHANNELS        = 6,
  parameter int CNT_W           = 14,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SETTLE_CYCLES   = 16,
  parameter int QUEUE_EN        = 1,
  parameter int IDX_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  output logic                inc_clk,
  output logic                ref_clk,
  output logic                busy,
  output logic [CHANNELS-1:0] trig_vec,
  output logic [IDX_W-1:0]    trig_idx
);
  if (2**CNT_W <= DEBOUNCE_CYCLES || 2**CNT_W <= SETTLE_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES/SETTLE_CYCLES");
  end
  if (CHANNELS < 1 || CHANNELS > 16 || (2**IDX_W) < CHANNELS) begin : g_bad_channels
    $error("CHANNELS must be 1..16 and fit in IDX_W");
  end
  logic [CHANNELS-1:0] ev, pending, hit;
  logic [CNT_W-1:0] counter;
  state_t state;
  sync_edge_detect #(.CHANNELS(CHANNELS)) u_sync (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .rise_en(rise_en),
    .fall_en(fall_en),
    .ev(ev)
  );
  assign hit = ev | pending;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      pending <= '0;
      counter <= '0;
      trig_vec <= '0;
      trig_idx <= '0;
      inc_clk <= 1'b0;
      ref_clk <= 1'b0;
    end else begin
      if (QUEUE_EN != 0 && state != IDLE) pending <= pending | ev;
      case (state)
        IDLE:
          if (|hit) begin
            trig_vec <= hit;
            trig_idx <= IDX_W'(lowest_idx(16'(hit)));
            pending <= '0;
            inc_clk <= 1'b1;
            counter <= '0;
            state <= CALC;
          end
        // counting up to SETTLE_CYCLES puts ref_clk SETTLE_CYCLES+1 cycles after inc_clk
        CALC: begin
          inc_clk <= 1'b0;
          if (counter == CNT_W'(SETTLE_CYCLES)) begin
            ref_clk <= 1'b1;
            state <= REFRESH;
          end else counter <= counter + CNT_W'(1);
        end
        REFRESH: begin
          ref_clk <= 1'b0;
          counter <= '0;
          state <= DEBOUNCE;
        end
        DEBOUNCE:
          if (counter == CNT_W'(DEBOUNCE_CYCLES - 1)) state <= IDLE;
          else counter <= counter + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_input_trigger_mc.sv
// tb_input_trigger_mc: scoreboard bench running queued and non-queued instances side by side
module tb_input_trigger_mc;
  localparam int S = 4;
  localparam int D = 20;
  typedef struct {
    logic [3:0] vec;
    int         idx;
    int         t;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] trigger, rise_en, fall_en;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic int low_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Q = 1 - g;
    logic inc_clk, ref_clk, busy;
    logic [3:0] trig_vec;
    logic [1:0] trig_idx;
    input_trigger_mc #(
      .CHANNELS(4), .CNT_W(14), .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S), .QUEUE_EN(Q), .IDX_W(2)
    ) dut (
      .clk(clk),
      .reset(reset),
      .trigger(trigger),
      .rise_en(rise_en),
      .fall_en(fall_en),
      .inc_clk(inc_clk),
      .ref_clk(ref_clk),
      .busy(busy),
      .trig_vec(trig_vec),
      .trig_idx(trig_idx)
    );
    exp_t qi[$];
    int qr[$];
    int n = 0;
    int valid_from = 4;
    int free_at = 0;
    int lidx = 0;
    logic [3:0] h1 = '0, h2 = '0, h3 = '0, pend = '0, lvec = '0;
    // reference: edges between raw samples n-3 and n-2 are acted on at clock edge n
    always @(posedge clk) begin
      logic [3:0] ev, hit;
      n++;
      ev = (n >= valid_from) ? ((h2 & ~h3 & rise_en) | (~h2 & h3 & fall_en)) : 4'h0;
      if (!reset) begin
        valid_from = n + 4;
        free_at = 0;
        pend = '0;
        lvec = '0;
        lidx = 0;
        qi.delete();
        qr.delete();
      end else if (n >= free_at) begin
        hit = ev | pend;
        if (hit != 0) begin
          lvec = hit;
          lidx = low_idx(hit);
          pend = '0;
          qi.push_back(exp_t'{hit, lidx, n});
          qr.push_back(n + S + 1);
          free_at = n + S + D + 3;
        end
      end else if (Q != 0) pend |= ev;
      h3 = h2;
      h2 = h1;
      h1 = trigger;
    end
    always @(negedge clk) if (n > 0) begin
      bit ei, er;
      exp_t e;
      ei = qi.size() != 0 && qi[0].t == n;
      er = qr.size() != 0 && qr[0] == n;
      chk($sformatf("q%0d_inc_clk", Q), int'(inc_clk), int'(ei));
      chk($sformatf("q%0d_ref_clk", Q), int'(ref_clk), int'(er));
      if (ei) begin
        e = qi.pop_front();
        chk($sformatf("q%0d_inc_vec", Q), int'(trig_vec), int'(e.vec));
        chk($sformatf("q%0d_inc_idx", Q), int'(trig_idx), e.idx);
      end
      if (er) void'(qr.pop_front());
      chk($sformatf("q%0d_busy", Q), int'(busy), int'(n < free_at - 1));
      chk($sformatf("q%0d_trig_vec", Q), int'(trig_vec), int'(lvec));
      chk($sformatf("q%0d_trig_idx", Q), int'(trig_idx), lidx);
    end
  end
  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask
  initial begin
    reset = 1'b0;
    trigger = 4'hF;
    rise_en = 4'hF;
    fall_en = 4'h0;
    cyc(3);
    reset = 1'b1;
    cyc(30);
    trigger = 4'b0000; cyc(5);
    trigger = 4'b0100; cyc(40);
    trigger = 4'b0000; cyc(5);
    trigger = 4'b1010; cyc(40);
    trigger = 4'b0000; cyc(5);
    trigger = 4'b0100; cyc(14);
    trigger = 4'b0101; cyc(60);
    trigger = 4'b0000;
    rise_en = 4'b0000;
    fall_en = 4'b1000; cyc(5);
    trigger = 4'b1000; cyc(40);
    trigger = 4'b0000; cyc(40);
    trigger = 4'b1000; cyc(40);
    rise_en = 4'hF;
    fall_en = 4'h0;
    trigger = 4'b0000; cyc(5);
    trigger = 4'b0010; cyc(4);
    trigger = 4'b0011; cyc(1);
    reset = 1'b0; cyc(2);
    reset = 1'b1; cyc(40);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) trigger ^= 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        rise_en = 4'($urandom);
        fall_en = 4'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    reset = 1'b1;
    cyc(80);
    chk("q1_leftover_inc", g_dut[0].qi.size(), 0);
    chk("q1_leftover_ref", g_dut[0].qr.size(), 0);
    chk("q0_leftover_inc", g_dut[1].qi.size(), 0);
    chk("q0_leftover_ref", g_dut[1].qr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
